ldm_ctrl: RTL and testbench

LDM_CTRL -- requirements
Module: ldm_ctrl

---
 rtl/ldm_ctrl_if.sv | 34 +++
 rtl/ldm_ctrl.sv | 157 +++++++++++++++
 tb/tb_ldm_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldm_ctrl_if.sv
// Block-transfer (LDM/STM) sequencer port bundle: instruction, memory and register-file side.
// slave = sequencer side, master = pipeline/environment side.
interface ldm_ctrl_if;
    logic        i_start;
    logic [15:0] i_reg_list;
    logic        i_p;
    logic        i_u;
    logic        i_load;
    logic        i_wb;
    logic        i_mem_ready;
    logic        i_flush;
    logic [31:0] i_rf_data;
    logic [3:0]  o_rf_rd_code;
    logic [31:0] o_ldm_offset;
    logic        o_ldm_mem_vld;
    logic [3:0]  o_ldm_reg_code;
    logic [31:0] o_ldm_reg;
    logic        o_ldm_hold;
    logic        o_ldm_wb_vld;
    logic [31:0] o_ldm_wb_offset;
    logic        o_ldm_pc;

    modport slave (
        input  i_start, i_reg_list, i_p, i_u, i_load, i_wb, i_mem_ready, i_flush, i_rf_data,
        output o_rf_rd_code, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_reg,
               o_ldm_hold, o_ldm_wb_vld, o_ldm_wb_offset, o_ldm_pc
    );

    modport master (
        output i_start, i_reg_list, i_p, i_u, i_load, i_wb, i_mem_ready, i_flush, i_rf_data,
        input  o_rf_rd_code, o_ldm_offset, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_reg,
               o_ldm_hold, o_ldm_wb_vld, o_ldm_wb_offset, o_ldm_pc
    );
endinterface

// File: rtl/ldm_ctrl.sv
// LDM/STM sequencer: walks the register list lowest-first, one transfer per accepted cycle.
// Latency: first transfer the cycle after i_start; base writeback state only with LDM_BASE_WB_EN.
// Backpressure: i_mem_ready low holds every transfer output; i_flush aborts to IDLE.
module ldm_ctrl (
    input  logic       clk,
    input  logic       rst,
    ldm_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1
`ifdef LDM_BASE_WB_EN
        ,
        WB   = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] off_q, off_d;
    logic        load_q, load_d;

    logic [4:0]  list_cnt;
    logic [31:0] list_bytes;
    logic [31:0] start_off;
    logic [3:0]  lsb_idx;
    logic        xfer;
    logic        accept;
    logic        last;
    logic        start_acc;

    always_comb begin
        list_cnt = 5'd0;
        for (int k = 0; k < 16; k++) begin
            list_cnt = list_cnt + 5'(bus.i_reg_list[k]);
        end
    end

    assign list_bytes = {25'd0, list_cnt, 2'b00};

    // Start offset is relative to the base; the decrementing modes begin below it
    always_comb begin
        case ({bus.i_p, bus.i_u})
            2'b01:   start_off = 32'd0;
            2'b11:   start_off = 32'd4;
            2'b00:   start_off = 32'd4 - list_bytes;
            default: start_off = 32'd0 - list_bytes;
        endcase
    end

    always_comb begin
        lsb_idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (mask_q[k]) lsb_idx = 4'(k);
        end
    end

    assign xfer      = (state_q == XFER);
    assign accept    = xfer && bus.i_mem_ready;
    assign last      = ((mask_q & (mask_q - 16'd1)) == 16'd0);
    assign start_acc = (state_q == IDLE) && bus.i_start && !bus.i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            off_q   <= off_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        off_d   = off_q;
        load_d  = load_q;
        if (bus.i_flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        mask_d = bus.i_reg_list;
                        off_d  = start_off;
                        load_d = bus.i_load;
                        if (bus.i_reg_list != 16'd0) begin
                            state_d = XFER;
`ifdef LDM_BASE_WB_EN
                        end else if (bus.i_wb) begin
                            state_d = WB;
`endif
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        mask_d = mask_q & (mask_q - 16'd1);
                        off_d  = off_q + 32'd4;
                        if (last) begin
`ifdef LDM_BASE_WB_EN
                            state_d = WB;
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_ldm_mem_vld  = xfer;
    assign bus.o_ldm_reg_code = xfer ? lsb_idx : 4'd0;
    assign bus.o_rf_rd_code   = bus.o_ldm_reg_code;
    assign bus.o_ldm_offset   = xfer ? off_q : 32'd0;
    assign bus.o_ldm_pc       = xfer && load_q && (lsb_idx == 4'd15);
    assign bus.o_ldm_reg      = bus.i_rf_data;
    assign bus.o_ldm_hold     = (state_q != IDLE) || bus.i_start;

`ifdef LDM_BASE_WB_EN
    logic [4:0]  cnt_q;
    logic        u_q;
    logic        wb_q;
    logic [31:0] wb_bytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            u_q   <= 1'b0;
            wb_q  <= 1'b0;
        end else if (start_acc) begin
            cnt_q <= list_cnt;
            u_q   <= bus.i_u;
            wb_q  <= bus.i_wb;
        end
    end

    assign wb_bytes            = {25'd0, cnt_q, 2'b00};
    assign bus.o_ldm_wb_vld    = (state_q == WB) && wb_q;
    assign bus.o_ldm_wb_offset = (state_q != WB) ? 32'd0 :
                                 (u_q ? wb_bytes : 32'd0 - wb_bytes);
`else
    logic unused_wb;
    assign unused_wb           = bus.i_wb ^ start_acc;
    assign bus.o_ldm_wb_vld    = 1'b0;
    assign bus.o_ldm_wb_offset = 32'd0;
`endif

endmodule

// File: tb/tb_ldm_ctrl.sv
// Directed bench for ldm_ctrl: stimulus pushes expected transfers/writebacks, a negedge monitor pops and checks.
module tb_ldm_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldm_ctrl_if ifc ();
    ldm_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

    // Register file model: data identifies the register being read
    assign ifc.i_rf_data = {16'hDA7A, 12'h000, ifc.o_rf_rd_code};

    typedef struct packed {
        logic [31:0] off;
        logic [3:0]  code;
        logic        pc;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] wq[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ifc.o_ldm_mem_vld === 1'b1) begin
            if (xq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got code %0d offset %h, required no transfer",
                         ifc.o_ldm_reg_code, ifc.o_ldm_offset);
            end else begin
                chk("xfer_offset", ifc.o_ldm_offset, xq[0].off);
                chk("xfer_code", {28'd0, ifc.o_ldm_reg_code}, {28'd0, xq[0].code});
                chk("xfer_pc", {31'd0, ifc.o_ldm_pc}, {31'd0, xq[0].pc});
                chk("rd_code", {28'd0, ifc.o_rf_rd_code}, {28'd0, xq[0].code});
                chk("store_data", ifc.o_ldm_reg, {16'hDA7A, 12'h000, xq[0].code});
                if (ifc.i_mem_ready) void'(xq.pop_front());
            end
        end
        if (ifc.o_ldm_wb_vld === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got wb_offset %h, required no writeback", ifc.o_ldm_wb_offset);
            end else begin
                chk("wb_offset", ifc.o_ldm_wb_offset, wq[0]);
                void'(wq.pop_front());
            end
        end
    end

    task automatic start(input logic [15:0] list, input logic p, input logic u,
                         input logic load, input logic wb);
        ifc.i_start    = 1'b1;
        ifc.i_reg_list = list;
        ifc.i_p        = p;
        ifc.i_u        = u;
        ifc.i_load     = load;
        ifc.i_wb       = wb;
        at_neg();
        chk("start_hold", {31'd0, ifc.o_ldm_hold}, 32'd1);
        tick();
        ifc.i_start    = 1'b0;
        ifc.i_reg_list = 16'h0000;
    endtask

    // Called in the cycle after the last transfer
    task automatic post(input logic wb_exp);
`ifdef LDM_BASE_WB_EN
        at_neg();
        chk("wb_state_hold", {31'd0, ifc.o_ldm_hold}, 32'd1);
        chk("wb_state_vld", {31'd0, ifc.o_ldm_wb_vld}, {31'd0, wb_exp});
        chk("wb_state_mem_vld", {31'd0, ifc.o_ldm_mem_vld}, 32'd0);
        tick();
        at_neg();
        chk("idle_hold", {31'd0, ifc.o_ldm_hold}, 32'd0);
        chk("idle_wb_vld", {31'd0, ifc.o_ldm_wb_vld}, 32'd0);
        tick();
`else
        at_neg();
        chk("idle_hold", {31'd0, ifc.o_ldm_hold}, {31'd0, wb_exp & 1'b0});
        chk("idle_wb_vld", {31'd0, ifc.o_ldm_wb_vld}, 32'd0);
        chk("idle_wb_offset", ifc.o_ldm_wb_offset, 32'd0);
        chk("idle_mem_vld", {31'd0, ifc.o_ldm_mem_vld}, 32'd0);
        tick();
`endif
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_mem_vld"}, {31'd0, ifc.o_ldm_mem_vld}, 32'd0);
        chk({name, "_offset"}, ifc.o_ldm_offset, 32'd0);
        chk({name, "_code"}, {28'd0, ifc.o_ldm_reg_code}, 32'd0);
        chk({name, "_pc"}, {31'd0, ifc.o_ldm_pc}, 32'd0);
        chk({name, "_hold"}, {31'd0, ifc.o_ldm_hold}, 32'd0);
        chk({name, "_wb_vld"}, {31'd0, ifc.o_ldm_wb_vld}, 32'd0);
        chk({name, "_wb_offset"}, ifc.o_ldm_wb_offset, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        ifc.i_start     = 1'b0;
        ifc.i_reg_list  = 16'h0000;
        ifc.i_p         = 1'b0;
        ifc.i_u         = 1'b0;
        ifc.i_load      = 1'b0;
        ifc.i_wb        = 1'b0;
        ifc.i_mem_ready = 1'b1;
        ifc.i_flush     = 1'b0;
        tick();
        tick();
        at_neg();
        check_quiet("reset");
        tick();
        rst = 1'b0;

        // IA, four stores, writeback +16
        xq.push_back('{32'h0, 4'd4, 1'b0});
        xq.push_back('{32'h4, 4'd5, 1'b0});
        xq.push_back('{32'h8, 4'd6, 1'b0});
        xq.push_back('{32'hC, 4'd7, 1'b0});
`ifdef LDM_BASE_WB_EN
        wq.push_back(32'h0000_0010);
`endif
        start(16'h00F0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        post(1'b1);

        // DB load of r0 and r15
        xq.push_back('{32'hFFFF_FFF8, 4'd0, 1'b0});
        xq.push_back('{32'hFFFF_FFFC, 4'd15, 1'b1});
`ifdef LDM_BASE_WB_EN
        wq.push_back(32'hFFFF_FFF8);
`endif
        start(16'h8001, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        post(1'b1);

        // IB with a two-cycle stall on the second transfer; a start mid-sequence is ignored
        xq.push_back('{32'h4, 4'd0, 1'b0});
        xq.push_back('{32'h8, 4'd1, 1'b0});
        xq.push_back('{32'hC, 4'd2, 1'b0});
        start(16'h0007, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        ifc.i_mem_ready = 1'b0;
        ifc.i_start     = 1'b1;
        ifc.i_reg_list  = 16'h0300;
        at_neg();
        chk("stall_hold_1", {31'd0, ifc.o_ldm_hold}, 32'd1);
        tick();
        ifc.i_start     = 1'b0;
        ifc.i_reg_list  = 16'h0000;
        at_neg();
        chk("stall_hold_2", {31'd0, ifc.o_ldm_hold}, 32'd1);
        tick();
        ifc.i_mem_ready = 1'b1;
        tick();
        tick();
        post(1'b0);

        // Empty list without writeback
        start(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        at_neg();
        check_quiet("empty_next");
        tick();

        // Flush during the second of four transfers, then a fresh start
        xq.push_back('{32'h0, 4'd0, 1'b0});
        xq.push_back('{32'h4, 4'd1, 1'b0});
        start(16'h000F, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        ifc.i_flush = 1'b1;
        at_neg();
        chk("flush_cycle_hold", {31'd0, ifc.o_ldm_hold}, 32'd1);
        tick();
        ifc.i_flush = 1'b0;
        at_neg();
        check_quiet("after_flush");
        tick();
        xq.push_back('{32'h0, 4'd4, 1'b0});
        start(16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        post(1'b0);

        // Reset mid-sequence, then a single-register IA
        xq.push_back('{32'h0, 4'd4, 1'b0});
        xq.push_back('{32'h4, 4'd5, 1'b0});
        start(16'h00F0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        check_quiet("after_rst");
        tick();
        xq.push_back('{32'h0, 4'd0, 1'b0});
        start(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        post(1'b0);

        repeat (2) tick();
        chk("xfer_queue_left", 32'(xq.size()), 32'd0);
        chk("wb_queue_left", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
